// File: rtl/spiker_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spiker_capture_pkg
// Purpose  : Shared types and constants for the spiker result capture block.
//            cap_state_e : EMPTY (no result), ONE (front valid),
//                          FULL (front and back valid)
//            TSTAMP_W    : width of the cycle stamp carried with each bank
// Revision : 1.0 - initial release
// ============================================================================
package spiker_capture_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } cap_state_e;

  localparam int TSTAMP_W = 32;

endpackage
`default_nettype wire

// File: rtl/spiker_capture_bank.sv
`default_nettype none
// ============================================================================
// Module   : spiker_capture_bank
// Purpose  : One result bank: N_REG x WIDTH register array loaded as a whole
//            when ld_i is high. With SPIKER_CAPTURE_TSTAMP_EN defined it also
//            holds a TSTAMP_W-bit stamp loaded alongside the data.
// Ports    : clk_i        clock, rising edge
//            rst_i        asynchronous reset, active-high (clears the bank)
//            ld_i         load enable
//            ld_data_i    value loaded into the word array
//            ld_tstamp_i  value loaded into the stamp (macro only)
//            q_o          current word array
//            tstamp_o     current stamp (macro only)
// Config   : SPIKER_CAPTURE_TSTAMP_EN
// Revision : 1.0 - initial release
// ============================================================================
module spiker_capture_bank
  import spiker_capture_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_REG = 24
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        ld_i,
  input  logic [N_REG-1:0][WIDTH-1:0] ld_data_i,
`ifdef SPIKER_CAPTURE_TSTAMP_EN
  input  logic [TSTAMP_W-1:0]         ld_tstamp_i,
  output logic [TSTAMP_W-1:0]         tstamp_o,
`endif
  output logic [N_REG-1:0][WIDTH-1:0] q_o
);

  logic [N_REG-1:0][WIDTH-1:0] r_words;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_words <= '0;
    end else if (ld_i) begin
      r_words <= ld_data_i;
    end
  end

  assign q_o = r_words;

`ifdef SPIKER_CAPTURE_TSTAMP_EN
  logic [TSTAMP_W-1:0] r_tstamp;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tstamp <= '0;
    end else if (ld_i) begin
      r_tstamp <= ld_tstamp_i;
    end
  end

  assign tstamp_o = r_tstamp;
`endif

endmodule
`default_nettype wire

// File: rtl/spiker_result_capture.sv
`default_nettype none
// ============================================================================
// Module   : spiker_result_capture
// Purpose  : Captures the spiking core's wide result vector into WIDTH-bit
//            register-file words. A front/back bank pair queues up to two
//            results so a new one can land while software reads the last.
//            Counts accepted samples (wrapping) and dropped samples
//            (saturating) and flags drops with a sticky overflow bit.
// Ports    : clk_i         clock, rising edge
//            rst_i         asynchronous reset, active-high
//            data_i        core result vector, word i = data_i[(i+1)*WIDTH-1 -: WIDTH]
//            sample_i      1-cycle capture request
//            ack_i         1-cycle pulse, software consumed the front bank
//            clear_i       synchronous flush of state, flags and counters
//            result_o      front bank words
//            valid_o       front bank holds an unconsumed result
//            pending_o     back bank holds a queued result
//            overflow_o    sticky drop flag
//            sample_cnt_o  accepted samples, wraps
//            drop_cnt_o    dropped samples, saturates
//            tstamp_o      cycle stamp of the front bank (0 without macro)
// Config   : SPIKER_CAPTURE_TSTAMP_EN enables the cycle counter and stamps.
// Revision : 1.0 - initial release
// ============================================================================
module spiker_result_capture
  import spiker_capture_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int N_REG      = 24,
  parameter int DATA_WIDTH = N_REG * WIDTH,
  parameter int CNT_W      = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [DATA_WIDTH-1:0]       data_i,
  input  logic                        sample_i,
  input  logic                        ack_i,
  input  logic                        clear_i,
  output logic [N_REG-1:0][WIDTH-1:0] result_o,
  output logic                        valid_o,
  output logic                        pending_o,
  output logic                        overflow_o,
  output logic [CNT_W-1:0]            sample_cnt_o,
  output logic [CNT_W-1:0]            drop_cnt_o,
  output logic [TSTAMP_W-1:0]         tstamp_o
);

  generate
    if (DATA_WIDTH != N_REG * WIDTH) begin : g_width_chk
      $error("spiker_result_capture: DATA_WIDTH must equal N_REG*WIDTH");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Slice the flat core vector into register words
  // --------------------------------------------------------------------------
  logic [N_REG-1:0][WIDTH-1:0] w_data_words;

  generate
    for (genvar gi = 0; gi < N_REG; gi++) begin : g_slice
      assign w_data_words[gi] = data_i[(gi+1)*WIDTH-1 -: WIDTH];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  cap_state_e r_state;
  cap_state_e w_state_nxt;
  logic       w_front_ld;
  logic       w_front_from_back;
  logic       w_back_ld;
  logic       w_accept;
  logic       w_drop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_front_ld        = 1'b0;
    w_front_from_back = 1'b0;
    w_back_ld         = 1'b0;
    w_accept          = 1'b0;
    w_drop            = 1'b0;
    if (clear_i) begin
      // Flush wins over any sample/ack in the same cycle.
      w_state_nxt = EMPTY;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (sample_i) begin
            w_front_ld  = 1'b1;
            w_accept    = 1'b1;
            w_state_nxt = ONE;
          end
        end
        ONE: begin
          if (sample_i && ack_i) begin
            // Consumed result is replaced directly in the front bank.
            w_front_ld = 1'b1;
            w_accept   = 1'b1;
          end else if (sample_i) begin
            w_back_ld   = 1'b1;
            w_accept    = 1'b1;
            w_state_nxt = FULL;
          end else if (ack_i) begin
            w_state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (sample_i && ack_i) begin
            // Ack frees the front slot this cycle, so the sample fits.
            w_front_ld        = 1'b1;
            w_front_from_back = 1'b1;
            w_back_ld         = 1'b1;
            w_accept          = 1'b1;
          end else if (sample_i) begin
            w_drop = 1'b1;
          end else if (ack_i) begin
            w_front_ld        = 1'b1;
            w_front_from_back = 1'b1;
            w_state_nxt       = ONE;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
        end
      endcase
    end
  end

  assign valid_o   = (r_state != EMPTY);
  assign pending_o = (r_state == FULL);

  // --------------------------------------------------------------------------
  // Banks
  // --------------------------------------------------------------------------
  logic [N_REG-1:0][WIDTH-1:0] w_front_q;
  logic [N_REG-1:0][WIDTH-1:0] w_back_q;
  logic [N_REG-1:0][WIDTH-1:0] w_front_src;

  assign w_front_src = w_front_from_back ? w_back_q : w_data_words;

`ifdef SPIKER_CAPTURE_TSTAMP_EN
  logic [TSTAMP_W-1:0] r_cycle;
  logic [TSTAMP_W-1:0] w_front_ts;
  logic [TSTAMP_W-1:0] w_back_ts;
  logic [TSTAMP_W-1:0] w_front_ts_src;

  // Free-running from reset; clear_i does not restart it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + 1'b1;
    end
  end

  assign w_front_ts_src = w_front_from_back ? w_back_ts : r_cycle;
  assign tstamp_o       = w_front_ts;
`else
  assign tstamp_o = '0;
`endif

  spiker_capture_bank #(
    .WIDTH (WIDTH),
    .N_REG (N_REG)
  ) u_front (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ld_i        (w_front_ld),
    .ld_data_i   (w_front_src),
`ifdef SPIKER_CAPTURE_TSTAMP_EN
    .ld_tstamp_i (w_front_ts_src),
    .tstamp_o    (w_front_ts),
`endif
    .q_o         (w_front_q)
  );

  spiker_capture_bank #(
    .WIDTH (WIDTH),
    .N_REG (N_REG)
  ) u_back (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ld_i        (w_back_ld),
    .ld_data_i   (w_data_words),
`ifdef SPIKER_CAPTURE_TSTAMP_EN
    .ld_tstamp_i (r_cycle),
    .tstamp_o    (w_back_ts),
`endif
    .q_o         (w_back_q)
  );

  assign result_o = w_front_q;

  // --------------------------------------------------------------------------
  // Counters and sticky overflow
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_drop_cnt;
  logic             r_overflow;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sample_cnt <= '0;
      r_drop_cnt   <= '0;
      r_overflow   <= 1'b0;
    end else if (clear_i) begin
      r_sample_cnt <= '0;
      r_drop_cnt   <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sample_cnt <= r_sample_cnt + 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != {CNT_W{1'b1}}) begin
          r_drop_cnt <= r_drop_cnt + 1'b1;
        end
      end
    end
  end

  assign sample_cnt_o = r_sample_cnt;
  assign drop_cnt_o   = r_drop_cnt;
  assign overflow_o   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_spiker_result_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_spiker_result_capture
// Purpose  : Directed self-checking bench for spiker_result_capture.
//            Counters are narrowed to 8 bits so wrap and saturation are
//            reachable in a few hundred cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spiker_result_capture;

  localparam int W  = 32;
  localparam int NR = 24;
  localparam int DW = NR * W;
  localparam int CW = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [DW-1:0]        data = '0;
  logic                 sample = 1'b0;
  logic                 ack = 1'b0;
  logic                 clear = 1'b0;
  logic [NR-1:0][W-1:0] result;
  logic                 valid;
  logic                 pending;
  logic                 overflow;
  logic [CW-1:0]        sample_cnt;
  logic [CW-1:0]        drop_cnt;
  logic [31:0]          tstamp;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  spiker_result_capture #(
    .WIDTH      (W),
    .N_REG      (NR),
    .DATA_WIDTH (DW),
    .CNT_W      (CW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .data_i       (data),
    .sample_i     (sample),
    .ack_i        (ack),
    .clear_i      (clear),
    .result_o     (result),
    .valid_o      (valid),
    .pending_o    (pending),
    .overflow_o   (overflow),
    .sample_cnt_o (sample_cnt),
    .drop_cnt_o   (drop_cnt),
    .tstamp_o     (tstamp)
  );

  // Word k of the pattern = base + k
  function automatic logic [DW-1:0] mk(input int base);
    logic [DW-1:0] v;
    v = '0;
    for (int k = 0; k < NR; k++) v[k*W +: W] = W'(base + k);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [DW-1:0] exp);
    logic [DW-1:0] obs;
    obs = result;
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock with the given controls; outputs are settled 1 time unit after the edge.
  task automatic cyc(input logic s, input logic a, input logic c, input logic [DW-1:0] d);
    @(negedge clk);
    sample = s; ack = a; clear = c; data = d;
    @(posedge clk);
    #1;
    sample = 1'b0; ack = 1'b0; clear = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_scnt", 32'(sample_cnt), 32'd0);
    chk("rst_dcnt", 32'(drop_cnt), 32'd0);
    chk("rst_tstamp", tstamp, 32'd0);
    chk_res("rst_result", '0);
    @(negedge clk);
    rst = 1'b0;

    // 1: first sample, word k = k+1
    cyc(1, 0, 0, mk(1));
    chk("t1_valid", 32'(valid), 32'd1);
    chk("t1_pending", 32'(pending), 32'd0);
    chk("t1_word0", result[0], 32'd1);
    chk("t1_word23", result[23], 32'd24);
    chk_res("t1_result", mk(1));
    chk("t1_scnt", 32'(sample_cnt), 32'd1);

    // 2: second sample B queues behind A
    cyc(1, 0, 0, mk(32'h100));
    chk_res("t2_result", mk(1));
    chk("t2_pending", 32'(pending), 32'd1);
    chk("t2_scnt", 32'(sample_cnt), 32'd2);

    // 3: third sample C while FULL is dropped
    cyc(1, 0, 0, mk(32'h200));
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_dcnt", 32'(drop_cnt), 32'd1);
    chk("t3_scnt", 32'(sample_cnt), 32'd2);
    chk_res("t3_result", mk(1));
    chk("t3_pending", 32'(pending), 32'd1);

    // 4: FULL with sample D + ack: front <= B, back <= D
    cyc(1, 1, 0, mk(32'h300));
    chk_res("t4_result", mk(32'h100));
    chk("t4_pending", 32'(pending), 32'd1);
    chk("t4_dcnt", 32'(drop_cnt), 32'd1);
    chk("t4_scnt", 32'(sample_cnt), 32'd3);

    // ack in FULL: front <= back (D)
    cyc(0, 1, 0, mk(32'h999));
    chk_res("ack_full_result", mk(32'h300));
    chk("ack_full_pending", 32'(pending), 32'd0);
    chk("ack_full_valid", 32'(valid), 32'd1);

    // ack in ONE: EMPTY, result keeps stale D
    cyc(0, 1, 0, mk(32'h999));
    chk("ack_one_valid", 32'(valid), 32'd0);
    chk_res("ack_one_stale", mk(32'h300));

    // ack in EMPTY ignored
    cyc(0, 1, 0, mk(32'h999));
    chk("ack_empty_valid", 32'(valid), 32'd0);
    chk("ack_empty_overflow", 32'(overflow), 32'd1);

    // sample + ack in EMPTY behaves as sample alone
    cyc(1, 1, 0, mk(32'h400));
    chk("sa_empty_valid", 32'(valid), 32'd1);
    chk("sa_empty_pending", 32'(pending), 32'd0);
    chk_res("sa_empty_result", mk(32'h400));
    chk("sa_empty_scnt", 32'(sample_cnt), 32'd4);

    // sample + ack in ONE replaces front, stays ONE
    cyc(1, 1, 0, mk(32'h500));
    chk_res("sa_one_result", mk(32'h500));
    chk("sa_one_pending", 32'(pending), 32'd0);
    chk("sa_one_valid", 32'(valid), 32'd1);
    chk("sa_one_scnt", 32'(sample_cnt), 32'd5);

    // 5: clear with sample in same cycle
    cyc(1, 0, 1, mk(32'h600));
    chk("t5_valid", 32'(valid), 32'd0);
    chk("t5_pending", 32'(pending), 32'd0);
    chk("t5_overflow", 32'(overflow), 32'd0);
    chk("t5_scnt", 32'(sample_cnt), 32'd0);
    chk("t5_dcnt", 32'(drop_cnt), 32'd0);

    // 6a: 2^CW accepted samples wrap the counter to 0
    cyc(1, 0, 0, mk(32'h700));
    for (int i = 1; i < (1 << CW); i++) cyc(1, 1, 0, mk(32'h700 + i));
    chk("wrap_scnt", 32'(sample_cnt), 32'd0);
    chk("wrap_valid", 32'(valid), 32'd1);
    chk("wrap_result_w0", result[0], 32'h700 + 32'd255);

    // drop counter saturates at all-ones
    cyc(0, 0, 1, '0);
    cyc(1, 0, 0, mk(32'h800));
    cyc(1, 0, 0, mk(32'h900));
    for (int i = 0; i < 300; i++) cyc(1, 0, 0, mk(32'hA00));
    chk("sat_dcnt", 32'(drop_cnt), 32'd255);
    chk("sat_scnt", 32'(sample_cnt), 32'd2);
    chk("sat_overflow", 32'(overflow), 32'd1);
    chk_res("sat_result", mk(32'h800));

    // 6b: asynchronous reset mid-FULL, checked before the next clock edge
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_pending", 32'(pending), 32'd0);
    chk("arst_overflow", 32'(overflow), 32'd0);
    chk("arst_scnt", 32'(sample_cnt), 32'd0);
    chk("arst_dcnt", 32'(drop_cnt), 32'd0);
    chk("arst_tstamp", tstamp, 32'd0);
    chk_res("arst_result", '0);
    @(negedge clk);
    rst = 1'b0;

    // Back bank was discarded: a sample after reset lands in front only
    cyc(1, 0, 0, mk(32'hB00));
    cyc(0, 1, 0, '0);
    chk("post_rst_valid", 32'(valid), 32'd0);
    chk_res("post_rst_result", mk(32'hB00));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
